// File: rtl/vga_fb_scanout.sv
// On-chip framebuffer fed by painter pixel writes, scanned out as 640x480@60 VGA.
// Latency: RGB/sync/blank lag the h/v counters by 2 pixel periods; a write shows from the next scan of its pixel.
// Backpressure: none; a plot is accepted every clk and the scan never stalls.
module vga_fb_scanout #(
    parameter int H_RES  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_RES  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int COL_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic [COL_W-1:0] colour,
    input  logic             plot,
    output logic [7:0]       vga_r,
    output logic [7:0]       vga_g,
    output logic [7:0]       vga_b,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_blank_n,
    output logic             vga_sync_n,
    output logic             vga_clk,
    output logic             frame_tick,
    output logic             wr_drop
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
    // Row pitch is fixed at 640 by the shift-add address, even for a narrower H_RES.
    localparam int FB_PITCH = 640;
    localparam int FB_DEPTH = V_RES * FB_PITCH;
    localparam int AW       = $clog2(FB_DEPTH);

    localparam logic [9:0] H_VIS  = 10'(H_RES);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_BEG = 10'(H_RES + H_FP);
    localparam logic [9:0] HS_END = 10'(H_RES + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_VIS  = 10'(V_RES);
    localparam logic [9:0] V_VEND = 10'(V_RES - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_BEG = 10'(V_RES + V_FP);
    localparam logic [9:0] VS_END = 10'(V_RES + V_FP + V_SYNC - 1);

    typedef struct packed {
        logic vld;
        logic vis;
        logic hs_n;
        logic vs_n;
    } scan_ctl_t;

    function automatic logic [AW-1:0] fb_addr(input logic [9:0] row, input logic [9:0] col);
        return AW'({row, 9'b0}) + AW'({row, 7'b0}) + AW'(col);
    endfunction

    logic             pix_ph;
    logic             pix_en;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             h_wrap;
    scan_ctl_t        s0_ctl;
    logic [AW-1:0]    s0_addr;
    scan_ctl_t        s1_ctl;
    logic [AW-1:0]    rd_addr;
    logic [COL_W-1:0] rd_dat;
    logic [COL_W-1:0] px_col;
    logic             wr_in_range;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [COL_W-1:0] fb_mem [FB_DEPTH];

    assign pix_en     = pix_ph;
    assign vga_clk    = pix_ph;
    assign vga_sync_n = 1'b0;
    assign h_wrap     = (h_cnt == H_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_ph     <= 1'b0;
            h_cnt      <= '0;
            v_cnt      <= '0;
            frame_tick <= 1'b0;
        end else begin
            pix_ph     <= ~pix_ph;
            frame_tick <= pix_en && h_wrap && (v_cnt == V_VEND);
            if (pix_en) begin
                if (h_wrap) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end
        end
    end

    // Stage 0: decode the current counter position.
    always_comb begin
        s0_ctl      = '0;
        s0_ctl.vld  = 1'b1;
        s0_ctl.vis  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        s0_ctl.hs_n = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
        s0_ctl.vs_n = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
        s0_addr     = s0_ctl.vis ? fb_addr(v_cnt, h_cnt) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_ctl  <= '0;
            rd_addr <= '0;
        end else if (pix_en) begin
            s1_ctl  <= s0_ctl;
            rd_addr <= s0_addr;
        end
    end

    assign wr_in_range = (x < H_VIS) && (y < V_VIS);
    assign wr_en       = plot && !reset && wr_in_range;
    assign wr_addr     = fb_addr(y, x);

    // Read-before-write: a collision returns the stored colour, the new one shows next frame.
    always_ff @(posedge clk) begin
        rd_dat <= fb_mem[rd_addr];
        if (wr_en) begin
            fb_mem[wr_addr] <= colour;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_drop <= 1'b0;
        end else if (plot && !wr_in_range) begin
            wr_drop <= 1'b1;
        end
    end

    assign px_col = (s1_ctl.vld && s1_ctl.vis) ? rd_dat : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else if (pix_en) begin
            vga_r       <= {8{px_col[2]}};
            vga_g       <= {8{px_col[1]}};
            vga_b       <= {8{px_col[0]}};
            vga_hs      <= !s1_ctl.vld || s1_ctl.hs_n;
            vga_vs      <= !s1_ctl.vld || s1_ctl.vs_n;
            vga_blank_n <= s1_ctl.vld && s1_ctl.vis;
        end
    end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench: reduced-geometry scanout (16x12 visible, 24x16 total) plus a
// default-geometry instance for the 640/800 horizontal timing, both on shared stimulus.
// Backpressure: none exercised; plots are driven back-to-back at one per clk.
module tb_vga_fb_scanout;

    logic       clk;
    logic       reset;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] colour;
    logic       plot;

    logic [7:0] s_r, s_g, s_b;
    logic       s_hs, s_vs, s_blank_n, s_sync_n, s_clk, s_ft, s_drop;
    logic [7:0] f_r, f_g, f_b;
    logic       f_hs, f_vs, f_blank_n, f_sync_n, f_clk, f_ft, f_drop;

    vga_fb_scanout #(
        .H_RES(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_RES(12), .V_FP(1), .V_SYNC(2), .V_BP(1), .COL_W(3)
    ) u_dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hs(s_hs), .vga_vs(s_vs),
        .vga_blank_n(s_blank_n), .vga_sync_n(s_sync_n), .vga_clk(s_clk),
        .frame_tick(s_ft), .wr_drop(s_drop)
    );

    vga_fb_scanout u_full (
        .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot),
        .vga_r(f_r), .vga_g(f_g), .vga_b(f_b), .vga_hs(f_hs), .vga_vs(f_vs),
        .vga_blank_n(f_blank_n), .vga_sync_n(f_sync_n), .vga_clk(f_clk),
        .frame_tick(f_ft), .wr_drop(f_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int n = 0;
    logic [2:0] exp_fb [0:11][0:15];
    bit cnt_en = 0;
    int sm_mis = 0, full_mis = 0;
    int hs_lo = 0, vs_lo = 0, ft_cnt = 0, ft_first = 0, ft_last = 0;
    int full_hs_lo = 0, full_bl_hi = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] pat(input int xx, input int yy);
        return 3'((xx * 5 + yy * 3 + 2) % 8);
    endfunction

    function automatic logic [23:0] expand(input logic [2:0] c);
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    // Expected scan outputs for the sample taken just after edge n since the last reset.
    task automatic model_cmp();
        int p, hp, vp;
        logic vis, hs, vs, ft;
        logic [23:0] rgb;
        vis = 1'b0; hs = 1'b1; vs = 1'b1; rgb = '0;
        if (n >= 4) begin
            p  = ((n - 4) / 2) % 384;
            hp = p % 24;
            vp = p / 24;
            vis = (hp < 16) && (vp < 12);
            hs  = !(hp >= 18 && hp <= 21);
            vs  = !(vp >= 13 && vp <= 14);
            if (vis) rgb = expand(exp_fb[vp][hp]);
        end
        ft = ((n % 768) == 576);
        if ({s_r, s_g, s_b} !== rgb || s_blank_n !== vis || s_hs !== hs || s_vs !== vs ||
            s_ft !== ft || s_clk !== 1'(n % 2) || s_sync_n !== 1'b0)
            sm_mis++;
        if (cnt_en && n >= 4 && n < 1540) begin
            if (s_hs === 1'b0) hs_lo++;
            if (s_vs === 1'b0) vs_lo++;
            if (s_ft === 1'b1) begin
                ft_cnt++;
                if (ft_cnt == 1) ft_first = n;
                ft_last = n;
            end
        end
        if (n < 1540) begin
            vis = 1'b0; hs = 1'b1;
            p = -1;
            if (n >= 4) begin
                p   = (n - 4) / 2;
                vis = (p < 640);
                hs  = !(p >= 656 && p <= 751);
            end
            if (f_blank_n !== vis || f_hs !== hs || f_vs !== 1'b1 || f_clk !== 1'(n % 2))
                full_mis++;
            if (p >= 0 && p < 16) begin
                if ({f_r, f_g, f_b} !== expand(exp_fb[0][p])) full_mis++;
            end else if (!vis && {f_r, f_g, f_b} !== 24'h0) begin
                full_mis++;
            end
            if (cnt_en && n >= 4) begin
                if (f_hs === 1'b0) full_hs_lo++;
                if (f_blank_n === 1'b1) full_bl_hi++;
            end
        end
    endtask

    task automatic run_to(input int target);
        while (n < target) begin
            tick();
            model_cmp();
        end
    endtask

    task automatic do_plot(input int xx, input int yy, input logic [2:0] c);
        plot = 1'b1; x = 10'(xx); y = 10'(yy); colour = c;
        tick();
        plot = 1'b0;
    endtask

    initial begin
        reset = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0;
        tick(); tick(); tick();
        chk("rst_hs", s_hs, 1'b1);
        chk("rst_vs", s_vs, 1'b1);
        chk("rst_blank_n", s_blank_n, 1'b0);
        chk("rst_rgb", {s_r, s_g, s_b}, 24'h0);
        chk("rst_frame_tick", s_ft, 1'b0);
        chk("rst_wr_drop", s_drop, 1'b0);
        chk("rst_vga_clk", s_clk, 1'b0);
        chk("sync_n", s_sync_n, 1'b0);

        // Full-frame stream at one plot per clk.
        reset = 1'b0;
        for (int yy = 0; yy < 12; yy++) begin
            for (int xx = 0; xx < 16; xx++) begin
                plot = 1'b1; x = 10'(xx); y = 10'(yy); colour = pat(xx, yy);
                exp_fb[yy][xx] = pat(xx, yy);
                tick();
            end
        end
        plot = 1'b0;
        tick();
        chk("stream_no_drop", s_drop, 1'b0);

        do_plot(0, 0, 3'b100);   exp_fb[0][0]   = 3'b100;
        do_plot(15, 11, 3'b010); exp_fb[11][15] = 3'b010;

        do_plot(16, 5, 3'b111);
        tick();
        chk("drop_x_oob", s_drop, 1'b1);
        do_plot(3, 12, 3'b111);
        tick(); tick();
        chk("drop_sticky", s_drop, 1'b1);
        chk("full_no_drop", f_drop, 1'b0);

        // Plot while reset is high must be ignored; this reset also starts the scan checks.
        reset = 1'b1; plot = 1'b1; x = 10'd2; y = 10'd2; colour = ~pat(2, 2);
        tick();
        reset = 1'b0; plot = 1'b0;
        n = 0;
        chk("drop_cleared", s_drop, 1'b0);
        cnt_en = 1'b1;

        run_to(3);
        chk("fill_blank", s_blank_n, 1'b0);
        run_to(4);
        chk("first_px_rgb", {s_r, s_g, s_b}, 24'hFF0000);
        chk("first_px_blank_n", s_blank_n, 1'b1);
        chk("full_first_px_rgb", {f_r, f_g, f_b}, 24'hFF0000);
        run_to(10);
        chk("px_3_0_kept", {s_r, s_g, s_b}, expand(pat(3, 0)));
        run_to(104);
        chk("px_2_2_rst_plot", {s_r, s_g, s_b}, expand(pat(2, 2)));
        run_to(244);
        chk("px_0_5_kept", {s_r, s_g, s_b}, expand(pat(0, 5)));

        // Write (10,10) on the edge that reads it: old colour this frame, new next frame.
        run_to(502);
        plot = 1'b1; x = 10'd10; y = 10'd10; colour = 3'b111;
        run_to(503);
        plot = 1'b0;
        run_to(504);
        chk("collide_old", {s_r, s_g, s_b}, expand(pat(10, 10)));
        run_to(505);
        exp_fb[10][10] = 3'b111;
        run_to(562);
        chk("last_px_rgb", {s_r, s_g, s_b}, 24'h00FF00);
        run_to(1272);
        chk("collide_new", {s_r, s_g, s_b}, 24'hFFFFFF);

        run_to(1539);
        cnt_en = 1'b0;
        chk("scan_model_mis", 32'(sm_mis), 32'd0);
        chk("hs_low_cnt", 32'(hs_lo), 32'd256);
        chk("vs_low_cnt", 32'(vs_lo), 32'd192);
        chk("frame_tick_cnt", 32'(ft_cnt), 32'd2);
        chk("frame_tick_first", 32'(ft_first), 32'd576);
        chk("frame_tick_period", 32'(ft_last - ft_first), 32'd768);
        chk("full_model_mis", 32'(full_mis), 32'd0);
        chk("full_hs_low_cnt", 32'(full_hs_lo), 32'd192);
        chk("full_vis_cnt", 32'(full_bl_hi), 32'd1280);

        // Mid-frame reset at h=12, v=8 of the third frame.
        run_to(1944);
        chk("pre_rst_visible", s_blank_n, 1'b1);
        reset = 1'b1;
        tick();
        chk("mid_rst_blank_n", s_blank_n, 1'b0);
        chk("mid_rst_rgb", {s_r, s_g, s_b}, 24'h0);
        chk("mid_rst_hs", s_hs, 1'b1);
        chk("mid_rst_vs", s_vs, 1'b1);
        chk("mid_rst_vga_clk", s_clk, 1'b0);
        reset = 1'b0;
        n = 0;
        run_to(772);
        chk("post_rst_model_mis", 32'(sm_mis), 32'd0);
        chk("post_rst_full_mis", 32'(full_mis), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
